hilo_unit: RTL and testbench

Parametrised HI/LO special-register unit for the openMips datapath, placed alongside the regfile and fed from the MEM/WB stage. It holds the architectural HI and LO words, commits MTHI/MTLO and MULT/DIV results, and executes the multiply-accumulate family (MADD, MADDU, MSUB, MSUBU) as a two-cycle read-modify-write with a ready/flush handshake. It generalises HI/LO storage with independent half-writes, configurable width, and in-unit accumulation.

---
 rtl/hilo_pkg.sv | 35 +++
 rtl/hilo_mul.sv | 35 +++
 rtl/hilo_unit.sv | 107 ++++++++++
 tb/tb_hilo_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO special-register unit: op codes, FSM states
// and small decode helpers used by the unit and its multiplier.
package hilo_pkg;

  typedef enum logic [2:0] {
    HILO_NOP    = 3'd0,
    HILO_WRHI   = 3'd1,
    HILO_WRLO   = 3'd2,
    HILO_WRBOTH = 3'd3,
    HILO_MADD   = 3'd4,
    HILO_MADDU  = 3'd5,
    HILO_MSUB   = 3'd6,
    HILO_MSUBU  = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // All multiply-accumulate codes live in the upper half of the op space.
  function automatic logic is_mac(input op_t op);
    return (op == HILO_MADD) || (op == HILO_MADDU) ||
           (op == HILO_MSUB) || (op == HILO_MSUBU);
  endfunction

  function automatic logic is_sub(input op_t op);
    return (op == HILO_MSUB) || (op == HILO_MSUBU);
  endfunction

  function automatic logic is_signed_mac(input op_t op);
    return (op == HILO_MADD) || (op == HILO_MSUB);
  endfunction

endpackage

// File: rtl/hilo_mul.sv
// Signed/unsigned WIDTH x WIDTH multiplier with a registered 2*WIDTH product,
// loaded only when enabled so the product stays stable for the accumulate cycle.
module hilo_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] full;

  // Extending to 2*WIDTH and keeping the low 2*WIDTH bits gives the exact
  // signed or unsigned product, since it never exceeds that width.
  always_comb begin
    ext_a = {{WIDTH{a[WIDTH-1] & sign}}, a};
    ext_b = {{WIDTH{b[WIDTH-1] & sign}}, b};
    full  = ext_a * ext_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
    end else if (en) begin
      product <= full;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers with direct writes and a two-cycle
// multiply-accumulate path (product register, then accumulate and commit).
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             ready,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             mac_done
);

  state_t             state, state_n;
  op_t                op_c;
  logic               accept;
  logic               mul_en;
  logic               sub_q, sub_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               done_n;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_n;

  hilo_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (mul_en),
    .sign    (is_signed_mac(op_c)),
    .a       (src_a),
    .b       (src_b),
    .product (product)
  );

  assign op_c   = op_t'(op);
  assign ready  = (state == IDLE);
  assign accept = op_valid & ready & ~flush;
  assign acc    = {hi_o, lo_o};

  // No write can be accepted while in MUL, so the accumulate can read the
  // registered HI/LO directly without any bypass.
  always_comb begin
    state_n = state;
    hi_n    = hi_o;
    lo_n    = lo_o;
    done_n  = 1'b0;
    mul_en  = 1'b0;
    sub_n   = sub_q;
    acc_n   = sub_q ? (acc - product) : (acc + product);
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_c)
            HILO_WRHI:   hi_n = hi_i;
            HILO_WRLO:   lo_n = lo_i;
            HILO_WRBOTH: begin
              hi_n = hi_i;
              lo_n = lo_i;
            end
            default: begin
              if (is_mac(op_c)) begin
                mul_en  = 1'b1;
                sub_n   = is_sub(op_c);
                state_n = MUL;
              end
            end
          endcase
        end
      end
      MUL: begin
        state_n = IDLE;
        if (!flush) begin
          hi_n   = acc_n[2*WIDTH-1:WIDTH];
          lo_n   = acc_n[WIDTH-1:0];
          done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hi_o     <= '0;
      lo_o     <= '0;
      mac_done <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state    <= state_n;
      hi_o     <= hi_n;
      lo_o     <= lo_n;
      mac_done <= done_n;
      sub_q    <= sub_n;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed, table-driven bench for hilo_unit plus hand sequences for the
// ready/mac_done timing of a single MAC.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] hi_i, lo_i, src_a, src_b;
  logic        flush;
  logic        ready;
  logic [31:0] hi_o, lo_o;
  logic        mac_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [2:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        erdy;
    logic        edone;
  } vec_t;

  vec_t vecs[25];

  hilo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .ready    (ready),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .mac_done (mac_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] o,
                              input logic [31:0] h, input logic [31:0] l,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic f, input logic [31:0] eh,
                              input logic [31:0] el, input logic er,
                              input logic ed);
    vec_t t;
    t.rst = r; t.vld = v; t.op = o; t.hi = h; t.lo = l; t.a = a; t.b = b;
    t.flush = f; t.ehi = eh; t.elo = el; t.erdy = er; t.edone = ed;
    return t;
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, settle past it.
  task automatic apply_stimulus(input vec_t v);
    rst = v.rst; op_valid = v.vld; op = v.op; hi_i = v.hi; lo_i = v.lo;
    src_a = v.a; src_b = v.b; flush = v.flush;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check_output($sformatf("v%0d hi_o", i), hi_o, v.ehi);
    check_output($sformatf("v%0d lo_o", i), lo_o, v.elo);
    check_output($sformatf("v%0d ready", i), {31'd0, ready}, {31'd0, v.erdy});
    check_output($sformatf("v%0d mac_done", i), {31'd0, mac_done}, {31'd0, v.edone});
  endtask

  initial begin
    int busy;
    int pulses;
    vec_t v;

    rst = 1'b1; op_valid = 1'b0; op = '0; hi_i = '0; lo_i = '0;
    src_a = '0; src_b = '0; flush = 1'b0;

    //           rst vld op           hi            lo            a             b             fl  ehi           elo           rdy done
    vecs[0]  = mk(1, 0, HILO_NOP,    32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[1]  = mk(0, 1, HILO_WRBOTH, 32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h0,        0, 32'h12345678, 32'h9ABCDEF0, 1, 0);
    vecs[2]  = mk(0, 1, HILO_WRHI,   32'hFFFFFFFF, 32'h11111111, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'h9ABCDEF0, 1, 0);
    vecs[3]  = mk(0, 1, HILO_WRBOTH, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[4]  = mk(0, 1, HILO_MADD,   32'h0,        32'h0,        32'hFFFFFFFF, 32'h2,        0, 32'h0,        32'h0,        0, 0);
    vecs[5]  = mk(0, 0, HILO_NOP,    32'h0,        32'h0,        32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 1);
    vecs[6]  = mk(0, 1, HILO_NOP,    32'h5,        32'h5,        32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0);
    vecs[7]  = mk(0, 1, HILO_WRBOTH, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[8]  = mk(0, 1, HILO_MADDU,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h2,        0, 32'h0,        32'h0,        0, 0);
    vecs[9]  = mk(0, 0, HILO_NOP,    32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h00000001, 32'hFFFFFFFE, 1, 1);
    vecs[10] = mk(0, 1, HILO_WRBOTH, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 0);
    vecs[11] = mk(0, 1, HILO_MSUBU,  32'h0,        32'h0,        32'h1,        32'h1,        0, 32'h0,        32'h0,        0, 0);
    vecs[12] = mk(0, 0, HILO_NOP,    32'h0,        32'h0,        32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1);
    vecs[13] = mk(0, 1, HILO_MADD,   32'h0,        32'h0,        32'h3,        32'h4,        0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    vecs[14] = mk(0, 0, HILO_NOP,    32'h0,        32'h0,        32'h0,        32'h0,        1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    vecs[15] = mk(0, 1, HILO_WRLO,   32'h0,        32'h5,        32'h0,        32'h0,        1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    vecs[16] = mk(0, 1, HILO_MSUB,   32'h0,        32'h0,        32'h2,        32'h3,        0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    vecs[17] = mk(0, 1, HILO_WRLO,   32'h0,        32'h55,       32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 1);
    vecs[18] = mk(0, 1, HILO_WRLO,   32'h0,        32'h55,       32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'h00000055, 1, 0);
    vecs[19] = mk(0, 1, HILO_MADD,   32'h0,        32'h0,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'h00000055, 0, 0);
    vecs[20] = mk(0, 1, HILO_MADDU,  32'h0,        32'h0,        32'h2,        32'h3,        0, 32'hFFFFFFFF, 32'h0000005B, 1, 1);
    vecs[21] = mk(0, 1, HILO_MADDU,  32'h0,        32'h0,        32'h2,        32'h3,        0, 32'hFFFFFFFF, 32'h0000005B, 0, 0);
    vecs[22] = mk(0, 0, HILO_NOP,    32'h0,        32'h0,        32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'h00000061, 1, 1);
    vecs[23] = mk(0, 1, HILO_MADD,   32'h0,        32'h0,        32'h1,        32'h1,        0, 32'hFFFFFFFF, 32'h00000061, 0, 0);
    vecs[24] = mk(1, 1, HILO_WRBOTH, 32'h7,        32'h7,        32'h0,        32'h0,        1, 32'h0,        32'h0,        1, 0);

    for (int i = 0; i < 25; i++) begin
      apply_stimulus(vecs[i]);
      check_vec(i, vecs[i]);
    end

    // Signed MSUB of the most negative operands, with ready/mac_done timing
    // observed cycle by cycle under a bounded wait.
    v = mk(0, 1, HILO_MSUB, 32'h0, 32'h0, 32'h80000000, 32'h80000000, 0,
           32'h0, 32'h0, 0, 0);
    apply_stimulus(v);
    rst = 1'b0; op_valid = 1'b0; op = HILO_NOP; flush = 1'b0;
    busy = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (ready) break;
      busy++;
      if (mac_done) pulses++;
      @(posedge clk);
      #1;
    end
    if (mac_done) pulses++;
    check_output("msub busy cycles", busy, 32'd1);
    check_output("msub ready back", {31'd0, ready}, 32'd1);
    check_output("msub done pulses", pulses, 32'd1);
    check_output("msub hi_o", hi_o, 32'hC0000000);
    check_output("msub lo_o", lo_o, 32'h00000000);
    @(posedge clk);
    #1;
    check_output("msub done clears", {31'd0, mac_done}, 32'd0);
    check_output("msub hi hold", hi_o, 32'hC0000000);

    // Reset asserted in the MUL cycle discards the pending accumulate.
    v = mk(0, 1, HILO_MADDU, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
           32'hC0000000, 32'h0, 0, 0);
    apply_stimulus(v);
    check_vec(100, v);
    v = mk(1, 0, HILO_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1, 0);
    apply_stimulus(v);
    check_vec(101, v);
    v = mk(0, 0, HILO_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1, 0);
    apply_stimulus(v);
    check_vec(102, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
